// File: rtl/xil_fifo_pkg.sv
// Shared helpers for the single-clock SDP FIFO controller.
// No logic of its own: constant functions used at elaboration time.
// Supplies the occupancy width and the legal-parameter check.
package xil_fifo_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input longint v);
    int     r;
    longint x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Occupancy counter width: one bit wider than the address so that
  // a completely full RAM (DEP == 2^ADR) is representable.
  function automatic int occ_w(input int adr);
    return adr + 1;
  endfunction

  // Legal parameter set: depth fits the RAM, read latency 1..3,
  // almost-full threshold inside the depth.
  function automatic bit params_ok(input int adr, input int dep,
                                   input int del, input int aful);
    return (dep >= 2) &&
           (longint'(dep) <= (longint'(1) << adr)) &&
           (del >= 1) && (del <= 3) &&
           (aful >= 1) && (aful <= dep);
  endfunction

endpackage

// File: rtl/xil_fifo_wrap_ptr.sv
// Modulo-DEP address pointer with increment enable.
// Latency: registered, new value visible the cycle after inc_i.
// No backpressure: the caller only raises inc_i on an accepted beat.
module xil_fifo_wrap_ptr #(
  parameter int ADR = 10,
  parameter int DEP = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc_i,
  output logic [ADR-1:0] ptr_o
);

  // Explicit compare against the last slot so non-power-of-two depths wrap.
  localparam logic [ADR-1:0] LAST = ADR'(DEP - 1);

  logic [ADR-1:0] ptr_q;
  logic [ADR-1:0] ptr_d;

  // Next pointer: hold, step, or wrap from DEP-1 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADR'(1);
    end
  end

  // Pointer register with synchronous reset to slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/xil_fifo_sdp_1clk_ctrl.sv
// Push/pop FIFO control around a simple-dual-port RAM (xil_bram_sdp_1clk_wrap).
// Latency: pop-to-rvld DEL cycles; push-to-earliest-pop 1 cycle; flags lag accept by 1.
// Backpressure: push dropped while full, pop dropped while empty. Optional macro
// XIL_FIFO_ERR_FLAG_EN adds sticky ovf/udf flags; otherwise both are tied low.
module xil_fifo_sdp_1clk_ctrl
  import xil_fifo_pkg::*;
#(
  parameter int ADR  = 10,
  parameter int DAT  = 18,
  parameter int DEP  = 1024,
  parameter int DEL  = 1,
  parameter int AFUL = 1020
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DAT-1:0]         pdat,
  input  logic                   pop,
  output logic [DAT-1:0]         rdat,
  output logic                   rvld,
  output logic                   full,
  output logic                   empty,
  output logic                   afull,
  output logic [occ_w(ADR)-1:0]  cnt,
  output logic                   ovf,
  output logic                   udf,
  output logic                   ram_wen,
  output logic [ADR-1:0]         ram_wad,
  output logic [DAT-1:0]         ram_wda,
  output logic                   ram_ren,
  output logic [ADR-1:0]         ram_rad,
  input  logic [DAT-1:0]         ram_rda
);

  localparam int             CW     = occ_w(ADR);
  localparam logic [CW-1:0]  DEP_C  = CW'(DEP);
  localparam logic [CW-1:0]  AFUL_C = CW'(AFUL);

  // Refuse to elaborate with a depth the RAM cannot hold or an
  // unsupported read latency.
  if (!params_ok(ADR, DEP, DEL, AFUL)) begin : g_bad_params
    $error("xil_fifo_sdp_1clk_ctrl: illegal ADR/DEP/DEL/AFUL combination");
  end

  logic           wacc;
  logic           racc;
  logic [ADR-1:0] wptr;
  logic [ADR-1:0] rptr;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           full_q;
  logic           empty_q;
  logic           afull_q;
  logic [DEL-1:0] vld_q;

  // Acceptance uses the registered flags, so an entry written this cycle
  // is never read in the same cycle (no bypass through an empty FIFO).
  assign wacc = push & ~full_q;
  assign racc = pop  & ~empty_q;

  // RAM ports are driven straight from the accept terms and pointers.
  assign ram_wen = wacc;
  assign ram_wad = wptr;
  assign ram_wda = pdat;
  assign ram_ren = racc;
  assign ram_rad = rptr;

  xil_fifo_wrap_ptr #(
    .ADR (ADR),
    .DEP (DEP)
  ) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wacc),
    .ptr_o (wptr)
  );

  xil_fifo_wrap_ptr #(
    .ADR (ADR),
    .DEP (DEP)
  ) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (racc),
    .ptr_o (rptr)
  );

  // Next occupancy: simultaneous accept leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({wacc, racc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Count and status flags, all derived from the next count so they stay
  // coherent with cnt every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEP_C);
      empty_q <= (cnt_d == '0);
      afull_q <= (cnt_d >= AFUL_C);
    end
  end

  // Read-valid shift register matching the RAM read latency; reset flushes
  // any read still in flight so it never produces rvld.
  if (DEL == 1) begin : g_vld1
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q <= racc;
      end
    end
  end else begin : g_vldn
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q <= {vld_q[DEL-2:0], racc};
      end
    end
  end

  assign rvld  = vld_q[DEL-1];
  assign rdat  = ram_rda;
  assign cnt   = cnt_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign afull = afull_q;

`ifdef XIL_FIFO_ERR_FLAG_EN
  logic ovf_q;
  logic udf_q;

  // Sticky error flags: a request refused by full/empty latches until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push & full_q)  ovf_q <= 1'b1;
      if (pop  & empty_q) udf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  // Occupancy never exceeds the depth and the FIFO is never both full and empty.
  a_cnt_range : assert property (@(posedge clk) disable iff (rst) cnt_q <= DEP_C);
  a_flags_excl : assert property (@(posedge clk) disable iff (rst) !(full_q && empty_q));
  a_empty_cnt : assert property (@(posedge clk) disable iff (rst) empty_q == (cnt_q == '0));

endmodule

// File: doc/xil_fifo_sdp_1clk_ctrl.md
# xil_fifo_sdp_1clk_ctrl

Single-clock FIFO controller that drives a simple-dual-port RAM, `xil_bram_sdp_1clk_wrap`, and turns it into a push/pop FIFO. It sits directly upstream of the RAM wrapper. It owns the write and read pointers, the occupancy count and the status flags. It re-aligns read data with a valid strobe that accounts for the RAM read latency `DEL`.

## Interface
Parameters:
- `ADR`, 10: RAM address width.
- `DAT`, 18: data width.
- `DEP`, 1024: FIFO depth. Range is 2..2^ADR; non-power-of-two is legal.
- `DEL`, 1: RAM read latency in cycles, 1..3. Must equal the wrapper's `DEL`.
- `AFUL`, 1020: almost-full threshold, 1..DEP.

Ports. The block has one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `push` in 1: write request.
- `pdat` in DAT: write data.
- `pop` in 1: read request.
- `rdat` out DAT: read data, valid when `rvld`=1.
- `rvld` out 1: read data valid.
- `full` out 1: count == DEP.
- `empty` out 1: count == 0.
- `afull` out 1: count >= AFUL.
- `cnt` out ADR+1: occupancy, 0..DEP.
- `ovf` out 1: sticky overflow flag (see Configuration).
- `udf` out 1: sticky underflow flag (see Configuration).
- `ram_wen` out 1: RAM write enable.
- `ram_wad` out ADR: RAM write address.
- `ram_wda` out DAT: RAM write data.
- `ram_ren` out 1: RAM read enable.
- `ram_rad` out ADR: RAM read address.
- `ram_rda` in DAT: RAM read data.

## Operation
- **Push acceptance:** `wacc = push & ~full`.
- **Pop acceptance:** `racc = pop & ~empty`. Flags are registered, so acceptance uses start-of-cycle state.
- **RAM write side (combinational):** `ram_wen = wacc`, `ram_wad = wptr`, `ram_wda = pdat`.
- **RAM read side (combinational):** `ram_ren = racc`, `ram_rad = rptr`.
- **Pointers:** increment on their accept. They wrap from DEP-1 to 0 with an explicit compare, not a power-of-two rollover.
- **Count update:**
  - `cnt` += 1 on `wacc` only.
  - `cnt` -= 1 on `racc` only.
  - `cnt` is unchanged when both or neither are accepted.
- **Flags:** `full`, `empty` and `afull` are registered and computed from the next value of `cnt`. They are therefore coherent with `cnt` every cycle.
- **Full with push and pop together:** pop is accepted, push is dropped, and `cnt` becomes DEP-1.
- **Empty with push and pop together:** push is accepted, pop is dropped (no bypass path), and `cnt` becomes 1.
- **Read-data valid:** `rvld` is `racc` delayed by a DEL-stage shift register. `rdat = ram_rda` is passed through unregistered.
- **Read-after-write ordering:**
  - An entry written in cycle N can be popped no earlier than cycle N+1, because `empty` is registered.
  - The RAM returns old-write data for any address not written in the same cycle.
  - The controller never reads an address being written in the same cycle, except when `cnt`==0, where the read is blocked.
- **Reset:**
  - `wptr`=`rptr`=0, `cnt`=0.
  - `empty`=1, `full`=0, `afull`=0.
  - `rvld`=0 and the whole valid pipeline is cleared.
  - `ovf`=`udf`=0.
  - RAM contents are not cleared.
- **Reset during operation:** read data already in flight is discarded, meaning no `rvld` is produced for it.

## Timing
- Pop-to-data latency is DEL cycles: `racc` in cycle N gives `rvld`=1 with valid `rdat` in cycle N+DEL.
- Push-to-pop latency is 1 cycle: earliest `racc` is 1 cycle after the first `wacc` into an empty FIFO, so earliest `rvld` is 1+DEL cycles after it.
- Throughput: one push and one pop per cycle, sustained.
- Flags update the cycle after the accept that changes them.

## Configuration
- Macro: `XIL_FIFO_ERR_FLAG_EN`.
- **Defined:**
  - `ovf` sets on `push & full`.
  - `udf` sets on `pop & empty`.
  - Both are sticky until `rst`.
  - Both are registered and go high the cycle after the offending request.
- **Undefined:** `ovf` and `udf` are tied to 0 and no flops are inferred. Dropping behaviour is identical in both cases.

## Structure
- Package `xil_fifo_pkg` holds:
  - A `clog2` function.
  - The occupancy-width constant, `ADR+1`.
  - The parameter range check: an elaboration error for DEP > 2^ADR or DEL outside 1..3.
- Sub-module `xil_fifo_wrap_ptr` is a modulo-DEP counter with an increment enable and synchronous reset. It is instantiated twice, for `wptr` and `rptr`.
- The valid-delay pipeline is inline in the top module.

## Test plan
- **Basic round trip:** after reset, push 0x00001..0x00004 on consecutive cycles, then pop 4 → `rdat` returns 1,2,3,4, each `rvld` DEL cycles after its pop; `empty`=1 at the end.
- **Fill, flags and overflow:** DEP=5, AFUL=4; push 6 words →
  - `afull` rises after the 4th push;
  - `full` rises after the 5th;
  - the 6th push is dropped;
  - `ovf`=1 (macro defined) or 0 (macro undefined);
  - draining returns exactly 5 words.
- **Simultaneous push/pop:**
  - When full: push and pop together → `cnt` goes 5→4.
  - When empty: push and pop together → `cnt` goes 0→1 with no `rvld`, and `udf`=1 (macro defined).
- **Non-power-of-two wrap:** DEP=5; 13 push/pop pairs at a 1-deep occupancy → `ram_wad` sequence is 0,1,2,3,4,0,…; data is in order with no loss.
- **Reset mid-read:** DEL=3; pop in cycle N, assert `rst` in cycle N+1 → no `rvld` in N+3; `cnt`=0 and `empty`=1 after reset.
- **Streaming:** random push/pop at 50% each for 10k cycles against a reference queue model → zero mismatches; `cnt` matches the model every cycle.
